// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (LS), with one transaction in flight.
// Define ARB_ROUND_ROBIN_EN to resolve ties round-robin; otherwise LS wins every tie.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MASK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic                  ls_wen,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    input  logic [MASK_WIDTH-1:0] ls_wmask,
    output logic                  ls_rsp_valid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    localparam logic OwnerIf = 1'b0;
    localparam logic OwnerLs = 1'b1;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0] wmask_q, wmask_d;

    logic grant_if;
    logic grant_ls;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // On a tie, favour the side that did not win the previous accept.
    always_comb begin
        grant_ls = ls_req_valid && (!if_req_valid || (last_grant_q == OwnerIf));
        grant_if = if_req_valid && !grant_ls;
    end
`else
    always_comb begin
        grant_ls = ls_req_valid;
        grant_if = if_req_valid && !ls_req_valid;
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_ls) begin
                    state_d = StReq;
                    owner_d = OwnerLs;
                    addr_d  = ls_addr;
                    wen_d   = ls_wen;
                    wdata_d = ls_wdata;
                    wmask_d = ls_wmask;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = OwnerLs;
`endif
                end else if (grant_if) begin
                    state_d = StReq;
                    owner_d = OwnerIf;
                    addr_d  = if_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = OwnerIf;
`endif
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (mem_rsp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= OwnerIf;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= OwnerIf;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Handshakes are masked while rst is low so every output reads 0 during reset.
    always_comb begin
        if_req_ready  = rst && (state_q == StIdle) && grant_if;
        ls_req_ready  = rst && (state_q == StIdle) && grant_ls;
        mem_req_valid = rst && (state_q == StReq);
        if_rsp_valid  = rst && (state_q == StResp) && mem_rsp_valid && (owner_q == OwnerIf);
        ls_rsp_valid  = rst && (state_q == StResp) && mem_rsp_valid && (owner_q == OwnerLs);
        if_rdata      = if_rsp_valid ? mem_rdata : '0;
        ls_rdata      = ls_rsp_valid ? mem_rdata : '0;
        mem_addr      = addr_q;
        mem_wen       = wen_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store, backpressure, ties, reset mid-flight.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rdata      (if_rdata),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_addr       (ls_addr),
        .ls_wen        (ls_wen),
        .ls_wdata      (ls_wdata),
        .ls_wmask      (ls_wmask),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rdata      (ls_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the posedge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_valid  = 1'b0;
        if_addr       = '0;
        ls_req_valid  = 1'b0;
        ls_addr       = '0;
        ls_wen        = 1'b0;
        ls_wdata      = '0;
        ls_wmask      = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic test_reset();
        logic [4:0] hs;
        clear_inputs();
        rst = 1'b0;
        if_req_valid  = 1'b1;
        ls_req_valid  = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        tick();
        #1;
        hs = {if_req_ready, ls_req_ready, mem_req_valid, if_rsp_valid, ls_rsp_valid};
        vectors++;
        if (hs !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_handshakes: got %b, expected %b", hs, 5'b00000);
        end
        vectors++;
        if ({if_rdata, ls_rdata} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h/%h, expected 0/0", if_rdata, ls_rdata);
        end
        vectors++;
        if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== 137'h0) begin
            miscompares++;
            $display("FAIL reset_payload: got addr %h wen %b wdata %h wmask %h, expected all 0",
                     mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        rst = 1'b1;
        #1;
        // Idle after release: LS takes the tie in either arbitration mode.
        vectors++;
        if ({if_req_ready, ls_req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %b, expected 01", {if_req_ready, ls_req_ready});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_single_fetch();
        if_req_valid  = 1'b1;
        if_addr       = 64'h8000_0000;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'h0010_0073;
        #1;
        vectors++;
        if ({if_req_ready, ls_req_ready, mem_req_valid, if_rsp_valid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL fetch_accept: got %b, expected 1000",
                     {if_req_ready, ls_req_ready, mem_req_valid, if_rsp_valid});
        end
        tick();
        if_req_valid = 1'b0;
        if_addr      = 64'h1234;
        #1;
        vectors++;
        if ({mem_req_valid, if_req_ready, if_rsp_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL fetch_req: got %b, expected 100", {mem_req_valid, if_req_ready, if_rsp_valid});
        end
        vectors++;
        if ({mem_addr, mem_wen, mem_wmask} !== {64'h8000_0000, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL fetch_payload: got addr %h wen %b wmask %h, expected 80000000 0 00",
                     mem_addr, mem_wen, mem_wmask);
        end
        tick();
        #1;
        vectors++;
        if ({if_rsp_valid, ls_rsp_valid, if_rdata, ls_rdata} !== {2'b10, 64'h0010_0073, 64'h0}) begin
            miscompares++;
            $display("FAIL fetch_rsp: got v %b if_rdata %h ls_rdata %h, expected 10 00100073 0",
                     {if_rsp_valid, ls_rsp_valid}, if_rdata, ls_rdata);
        end
        tick();
        #1;
        vectors++;
        if ({if_rsp_valid, if_rdata} !== 65'h0) begin
            miscompares++;
            $display("FAIL fetch_after: got %b %h, expected 0 0", if_rsp_valid, if_rdata);
        end
        clear_inputs();
    endtask

    task automatic test_store();
        ls_req_valid  = 1'b1;
        ls_addr       = 64'h8000_1000;
        ls_wen        = 1'b1;
        ls_wdata      = 64'h1122_3344_5566_7788;
        ls_wmask      = 8'hFF;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hDEAD_BEEF;
        #1;
        vectors++;
        if ({if_req_ready, ls_req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL store_accept: got %b, expected 01", {if_req_ready, ls_req_ready});
        end
        tick();
        ls_req_valid = 1'b0;
        #1;
        vectors++;
        if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
            {1'b1, 64'h8000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'hFF}) begin
            miscompares++;
            $display("FAIL store_payload: got v %b addr %h wen %b wdata %h wmask %h",
                     mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        tick();
        #1;
        vectors++;
        if ({if_rsp_valid, ls_rsp_valid, ls_rdata, if_rdata} !== {2'b01, 64'hDEAD_BEEF, 64'h0}) begin
            miscompares++;
            $display("FAIL store_rsp: got v %b ls_rdata %h if_rdata %h, expected 01 deadbeef 0",
                     {if_rsp_valid, ls_rsp_valid}, ls_rdata, if_rdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_backpressure();
        if_req_valid  = 1'b1;
        if_addr       = 64'h8000_0040;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'h13;
        tick();
        // Both sides now request new work; nothing may be accepted while REQ is pending.
        ls_req_valid = 1'b1;
        ls_addr      = 64'h9999;
        if_addr      = 64'h7777;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if ({mem_req_valid, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_addr}
                !== {5'b10000, 64'h8000_0040}) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: got %b addr %h, expected 10000 80000040", i,
                         {mem_req_valid, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid},
                         mem_addr);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        #1;
        vectors++;
        if ({if_rsp_valid, ls_rsp_valid, if_rdata} !== {2'b10, 64'h13}) begin
            miscompares++;
            $display("FAIL backpressure_rsp: got %b %h, expected 10 13",
                     {if_rsp_valid, ls_rsp_valid}, if_rdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_back_to_back_ties();
        logic exp_ls;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        if_req_valid  = 1'b1;
        if_addr       = 64'h100;
        ls_req_valid  = 1'b1;
        ls_addr       = 64'h200;
        ls_wen        = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'h55;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_ls = (i % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            #1;
            vectors++;
            if ({if_req_ready, ls_req_ready} !== {!exp_ls, exp_ls}) begin
                miscompares++;
                $display("FAIL tie_grant[%0d]: got %b, expected %b", i,
                         {if_req_ready, ls_req_ready}, {!exp_ls, exp_ls});
            end
            tick();
            #1;
            vectors++;
            if ({mem_req_valid, mem_wen} !== {1'b1, exp_ls}) begin
                miscompares++;
                $display("FAIL tie_req[%0d]: got %b, expected %b", i, {mem_req_valid, mem_wen},
                         {1'b1, exp_ls});
            end
            tick();
            #1;
            vectors++;
            if ({if_rsp_valid, ls_rsp_valid} !== {!exp_ls, exp_ls}) begin
                miscompares++;
                $display("FAIL tie_rsp[%0d]: got %b, expected %b", i,
                         {if_rsp_valid, ls_rsp_valid}, {!exp_ls, exp_ls});
            end
            if (i == 3) begin
                clear_inputs();
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_operation();
        if_req_valid  = 1'b1;
        if_addr       = 64'h8000_0080;
        mem_req_ready = 1'b1;
        tick();
        if_req_valid = 1'b0;
        tick();
        // Now in RESP with no memory response yet; abandon it.
        rst = 1'b0;
        #1;
        vectors++;
        if ({if_req_ready, ls_req_ready, mem_req_valid, if_rsp_valid, ls_rsp_valid} !== 5'b00000) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %b, expected 00000",
                     {if_req_ready, ls_req_ready, mem_req_valid, if_rsp_valid, ls_rsp_valid});
        end
        tick();
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hBAD;
        #1;
        vectors++;
        if ({if_rsp_valid, ls_rsp_valid, if_rdata, ls_rdata} !== 130'h0) begin
            miscompares++;
            $display("FAIL midreset_late_rsp: got %b %h %h, expected 00 0 0",
                     {if_rsp_valid, ls_rsp_valid}, if_rdata, ls_rdata);
        end
        tick();
        ls_req_valid = 1'b1;
        ls_addr      = 64'h8000_2000;
        mem_rdata    = 64'hCAFE;
        #1;
        vectors++;
        if (ls_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_next_accept: got %b, expected 1", ls_req_ready);
        end
        tick();
        ls_req_valid = 1'b0;
        #1;
        vectors++;
        if ({mem_req_valid, mem_addr, mem_wen} !== {1'b1, 64'h8000_2000, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_next_req: got %b %h %b, expected 1 80002000 0",
                     mem_req_valid, mem_addr, mem_wen);
        end
        tick();
        #1;
        vectors++;
        if ({ls_rsp_valid, if_rsp_valid, ls_rdata} !== {2'b10, 64'hCAFE}) begin
            miscompares++;
            $display("FAIL midreset_next_rsp: got %b %h, expected 10 cafe",
                     {ls_rsp_valid, if_rsp_valid}, ls_rdata);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_backpressure();
        test_back_to_back_ties();
        test_reset_mid_operation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
